turbo_iter_sched: RTL and testbench
===================================

# turbo_iter_sched

Iteration scheduler for the max-log-MAP turbo decoder. It sequences the shared alpha recursion pipeline (the SYMBOLS-deep alpha element chain) between the two constituent decoders, one half-iteration at a time. It issues one in_valid pulse per half-iteration, waits for the chain's out_valid, strobes extrinsic LLR capture, flips the decoder select, and counts full iterations until the programmed count is reached or an early stop is signalled. It sits between the top-level frame controller and the alpha/beta/LLR datapath.

## Interface
- SYMBOLS, 10, symbols per block; informational only, sets the default of ARRAY_LATENCY
- ARRAY_LATENCY, SYMBOLS+1, cycles from alpha_in_valid to alpha_out_valid of the alpha chain
- ITER_BITS, 4, width of the iteration count
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with TIMEOUT_EN
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request; sampled only in IDLE
- num_iter  in  ITER_BITS  full iterations to run; latched on the accepted start; 0 treated as 1
- early_stop  in  1  stop request; sampled only in UPDATE when dec_sel=1
- alpha_out_valid  in  1  completion pulse from the alpha chain
- alpha_in_valid  out  1  one-cycle launch pulse to the alpha chain
- dec_sel  out  1  0 = constituent decoder 1, 1 = decoder 2; selects branch metric and interleaver muxes
- llr_load  out  1  one-cycle strobe to capture extrinsic LLRs
- iter_count  out  ITER_BITS  completed full iterations
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  sticky watchdog error flag

## Operation
- States: IDLE, ISSUE, WAIT, UPDATE, DONE.
- IDLE:
  - On start: latch num_iter (0 becomes 1), clear iter_count and dec_sel, clear timeout_err, go to ISSUE.
- ISSUE:
  - alpha_in_valid=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - On alpha_out_valid, go to UPDATE.
  - alpha_out_valid seen in any other state is ignored.
- UPDATE:
  - llr_load=1 for this cycle.
  - If dec_sel=0: set dec_sel=1, go to ISSUE.
  - If dec_sel=1: iter_count+1 is written; set dec_sel=0.
  - If iter_count+1 == latched count, or early_stop=1, go to DONE; otherwise go to ISSUE.
  - Both conditions true at once: go to DONE, iter_count = count.
- DONE:
  - done=1 for this cycle, then go to IDLE.
  - iter_count and timeout_err hold until the next accepted start.
- start while busy is ignored. start in the same cycle as done is ignored, because the FSM is not yet in IDLE.
- iter_count never wraps: the maximum count is 2^ITER_BITS−1.
- Reset values of all outputs are 0. State resets to IDLE.
- Asserting rst_n low mid-frame aborts immediately. No done pulse is produced.

## Timing
- Accepted start at cycle s: first alpha_in_valid at s+1.
- Half-iteration period is ARRAY_LATENCY+2 cycles:
  - ISSUE at t.
  - alpha_out_valid at t+L.
  - UPDATE/llr_load at t+L+1.
  - Next ISSUE at t+L+2.
- N full iterations, no early stop: done at s+2N(L+2)+1.
- dec_sel changes only on the clock edge leaving UPDATE, so it is stable from ISSUE through UPDATE of each half-iteration.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- TIMEOUT_EN defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If TIMEOUT_CYCLES cycles elapse without alpha_out_valid, set timeout_err=1 and go to DONE (done pulses).
  - No llr_load is produced for that half-iteration.
- TIMEOUT_EN undefined:
  - No counter is built; timeout_err is tied 0.
  - WAIT waits indefinitely.

## Test plan
- Reset then start with num_iter=1, L=11, early_stop=0:
  - alpha_in_valid at s+1 and s+14.
  - llr_load at s+13 and s+26.
  - dec_sel 0 then 1.
  - done at s+27, iter_count=1.
- num_iter=3: six alpha_in_valid pulses, done at s+79, iter_count=3.
- num_iter=0: identical behaviour to num_iter=1.
- num_iter=4 with early_stop=1 held through the 2nd decoder-2 UPDATE:
  - done 1 cycle after that UPDATE, iter_count=2.
  - early_stop during decoder-1 UPDATEs has no effect.
- start pulsed mid-frame, plus a spurious alpha_out_valid during ISSUE/IDLE:
  - No extra launches, schedule unchanged.
  - Then rst_n low mid-WAIT: all outputs 0 immediately, IDLE, no done.
- TIMEOUT_EN with TIMEOUT_CYCLES=64 and alpha_out_valid held 0:
  - done and timeout_err 64 cycles after WAIT entry, no llr_load.
  - timeout_err clears on the next accepted start.
  - Without TIMEOUT_EN, busy stays 1 indefinitely.

Source files
------------

// File: rtl/turbo_iter_sched_if.sv
// rtl/turbo_iter_sched_if.sv - signal bundle between the iteration scheduler and its neighbours
//
// Purpose: groups the frame-control and alpha-chain handshake signals of
// turbo_iter_sched so they travel as one port.
//   master : the scheduler side (drives launch, select, strobes and status)
//   slave  : the frame controller / alpha datapath side
// Signals:
//   start, num_iter, early_stop   frame controller -> scheduler
//   alpha_out_valid               alpha chain      -> scheduler
//   alpha_in_valid, dec_sel,      scheduler        -> datapath
//   llr_load
//   iter_count, busy, done,       scheduler        -> frame controller
//   timeout_err
interface turbo_iter_sched_if #(
   parameter int ITER_BITS = 4
);
   logic                 start;
   logic [ITER_BITS-1:0] num_iter;
   logic                 early_stop;
   logic                 alpha_out_valid;
   logic                 alpha_in_valid;
   logic                 dec_sel;
   logic                 llr_load;
   logic [ITER_BITS-1:0] iter_count;
   logic                 busy;
   logic                 done;
   logic                 timeout_err;

   modport master (
      input  start, num_iter, early_stop, alpha_out_valid,
      output alpha_in_valid, dec_sel, llr_load, iter_count, busy, done, timeout_err
   );

   modport slave (
      output start, num_iter, early_stop, alpha_out_valid,
      input  alpha_in_valid, dec_sel, llr_load, iter_count, busy, done, timeout_err
   );
endinterface

// File: rtl/turbo_iter_sched.sv
// rtl/turbo_iter_sched.sv - half-iteration scheduler for the max-log-MAP turbo decoder
//
// Purpose: time-shares the alpha recursion chain between the two constituent
// decoders. Each half-iteration launches the chain once, waits for its
// completion, strobes extrinsic LLR capture and flips the decoder select.
// Full iterations are counted until the latched count is reached or an
// early stop is requested at the end of a decoder-2 half.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus (master modport)  start/num_iter/early_stop/alpha_out_valid in;
//                         alpha_in_valid/dec_sel/llr_load/iter_count/
//                         busy/done/timeout_err out (all registered)
//
// Optional feature macro: TIMEOUT_EN
//   defined   : WAIT watchdog of TIMEOUT_CYCLES cycles; on expiry sets the
//               sticky timeout_err and finishes the frame through DONE.
//   undefined : no watchdog, WAIT waits indefinitely, timeout_err is 0.
module turbo_iter_sched #(
   parameter int SYMBOLS        = 10,
   parameter int ARRAY_LATENCY  = SYMBOLS + 1,
   parameter int ITER_BITS      = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   turbo_iter_sched_if.master bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      UPDATE = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t               state;
   logic [ITER_BITS-1:0] iter_target;
   logic [ITER_BITS-1:0] iter_count_q;
   logic [ITER_BITS-1:0] iter_inc;
   logic                 alpha_in_valid_q;
   logic                 dec_sel_q;
   logic                 llr_load_q;
   logic                 busy_q;
   logic                 done_q;

   // The scheduler follows alpha_out_valid rather than counting the chain
   // latency, so the geometry parameters only document the chain it drives.
   logic [31:0] unused_cfg;
   assign unused_cfg = 32'(SYMBOLS + ARRAY_LATENCY + TIMEOUT_CYCLES);

`ifdef TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] wait_cnt;
   logic            timeout_err_q;
`endif

   // The latched count is never below 1 and iter_count stays below it until
   // the final update, so this increment cannot wrap.
   assign iter_inc = iter_count_q + ITER_BITS'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         iter_target      <= '0;
         iter_count_q     <= '0;
         alpha_in_valid_q <= 1'b0;
         dec_sel_q        <= 1'b0;
         llr_load_q       <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
`ifdef TIMEOUT_EN
         wait_cnt         <= '0;
         timeout_err_q    <= 1'b0;
`endif
      end else begin
         // Pulse outputs are one cycle wide unless re-armed below.
         alpha_in_valid_q <= 1'b0;
         llr_load_q       <= 1'b0;
         done_q           <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.start) begin
                  iter_target      <= (bus.num_iter == '0) ? ITER_BITS'(1) : bus.num_iter;
                  iter_count_q     <= '0;
                  dec_sel_q        <= 1'b0;
                  busy_q           <= 1'b1;
                  alpha_in_valid_q <= 1'b1;
                  state            <= ISSUE;
`ifdef TIMEOUT_EN
                  timeout_err_q    <= 1'b0;
`endif
               end
            end

            ISSUE: begin
               state <= WAIT;
`ifdef TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end

            WAIT: begin
               if (bus.alpha_out_valid) begin
                  llr_load_q <= 1'b1;
                  state      <= UPDATE;
               end
`ifdef TIMEOUT_EN
               else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  // Chain never answered: abandon the frame without capturing LLRs.
                  timeout_err_q <= 1'b1;
                  done_q        <= 1'b1;
                  state         <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + TO_W'(1);
               end
`endif
            end

            UPDATE: begin
               if (!dec_sel_q) begin
                  dec_sel_q        <= 1'b1;
                  alpha_in_valid_q <= 1'b1;
                  state            <= ISSUE;
               end else begin
                  // End of decoder 2 closes a full iteration.
                  iter_count_q <= iter_inc;
                  dec_sel_q    <= 1'b0;
                  if ((iter_inc == iter_target) || bus.early_stop) begin
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     alpha_in_valid_q <= 1'b1;
                     state            <= ISSUE;
                  end
               end
            end

            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.alpha_in_valid = alpha_in_valid_q;
   assign bus.dec_sel        = dec_sel_q;
   assign bus.llr_load       = llr_load_q;
   assign bus.iter_count     = iter_count_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
`ifdef TIMEOUT_EN
   assign bus.timeout_err    = timeout_err_q;
`else
   assign bus.timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_turbo_iter_sched.sv
// tb/tb_turbo_iter_sched.sv - randomized self-checking bench for turbo_iter_sched
module tb_turbo_iter_sched;
   localparam int ITER_BITS = 4;
   localparam int TO_CYC    = 64;

   logic clk;
   logic rst_n;

   turbo_iter_sched_if #(.ITER_BITS(ITER_BITS)) bus ();

   turbo_iter_sched #(
      .SYMBOLS(10),
      .ITER_BITS(ITER_BITS),
      .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Frame model state: cycle c counts from the cycle start is presented (c=0).
   int m_lat, m_p, m_d, m_neff;
   int m_prev_ic   = 0;
   int m_prev_terr = 0;
   int cur_c;
   bit chk_en = 0;
   logic e_aiv, e_llr, e_dec, e_busy, e_done, e_terr;
   int   e_ic;

   int q_aiv[$];
   int q_llr[$];
   int q_dec_launch[$];
   int done_at;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         if (err_cnt <= 40)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   // Expected outputs for frame cycle c from the schedule arithmetic:
   // half h occupies cycles [1+h*P, (h+1)*P], launch first, UPDATE last,
   // done at 2*neff*P+1, idle afterwards.
   task automatic model_at(input int c);
      int off, h;
      e_aiv = 0; e_llr = 0; e_dec = 0; e_busy = 0; e_done = 0; e_terr = 0;
      e_ic  = m_neff;
      if (c == 0) begin
         e_ic   = m_prev_ic;
         e_terr = 1'(m_prev_terr);
      end else if (c < m_d) begin
         off    = (c - 1) % m_p;
         h      = (c - 1) / m_p;
         e_aiv  = (off == 0);
         e_llr  = (off == m_lat + 1);
         e_dec  = 1'(h % 2);
         e_ic   = h / 2;
         e_busy = 1;
      end else if (c == m_d) begin
         e_busy = 1;
         e_done = 1;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("alpha_in_valid", 32'(bus.alpha_in_valid), 32'(e_aiv));
         check("llr_load",       32'(bus.llr_load),       32'(e_llr));
         check("dec_sel",        32'(bus.dec_sel),        32'(e_dec));
         check("iter_count",     32'(bus.iter_count),     32'(e_ic));
         check("busy",           32'(bus.busy),           32'(e_busy));
         check("done",           32'(bus.done),           32'(e_done));
         check("timeout_err",    32'(bus.timeout_err),    32'(e_terr));
         if (bus.alpha_in_valid === 1'b1) begin
            q_aiv.push_back(cur_c);
            q_dec_launch.push_back(int'(bus.dec_sel));
         end
         if (bus.llr_load === 1'b1) q_llr.push_back(cur_c);
         if (bus.done === 1'b1 && done_at < 0) done_at = cur_c;
      end
   end

   // Runs one frame from the current posedge+1. es_pct: random early_stop
   // density; stop_k>0: early_stop only around the k-th decoder-2 UPDATE and
   // on every decoder-1 UPDATE; noise: spurious start/alpha_out_valid.
   task automatic run_frame(input int n_in, input int lat, input int es_pct,
                            input int stop_k, input bit noise, input int gap);
      int n, p, neff, d, off;
      bit es[];
      n  = (n_in == 0) ? 1 : n_in;
      p  = lat + 2;
      es = new[2 * n * p + 2];
      for (int c = 0; c < es.size(); c++) es[c] = (int'($urandom_range(99)) < es_pct);
      if (stop_k > 0) begin
         for (int c = 0; c < es.size(); c++) es[c] = 1'b0;
         for (int k = 1; k <= n; k++) es[(2 * k - 1) * p] = 1'b1;
         for (int c = 2 * stop_k * p - 4; c <= 2 * stop_k * p; c++) es[c] = 1'b1;
      end
      neff = n;
      for (int k = n; k >= 1; k--) if (es[2 * k * p]) neff = k;
      d = 2 * neff * p + 1;
      m_lat = lat; m_p = p; m_d = d; m_neff = neff;
      q_aiv.delete(); q_llr.delete(); q_dec_launch.delete(); done_at = -1;

      for (int c = 0; c <= d + 1 + gap; c++) begin
         bus.start      = (c == 0) || (noise && c >= 1 && c <= d && $urandom_range(3) == 0);
         bus.num_iter   = (c == 0) ? ITER_BITS'(n_in) : ITER_BITS'($urandom);
         bus.early_stop = (c < es.size()) ? es[c] : 1'($urandom_range(1));
         if (c >= 1 && c < d) begin
            off = (c - 1) % p;
            bus.alpha_out_valid = (off == lat) ||
               (noise && (off == 0 || off == lat + 1) && $urandom_range(2) == 0);
         end else begin
            bus.alpha_out_valid = noise && $urandom_range(2) == 0;
         end
         cur_c = c;
         model_at(c);
         chk_en = 1;
         @(posedge clk); #1;
      end
      chk_en      = 0;
      m_prev_ic   = neff;
      m_prev_terr = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_prev_ic = 0;
      m_prev_terr = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      bus.start = 0; bus.num_iter = '0; bus.early_stop = 0; bus.alpha_out_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_alpha_in_valid", 32'(bus.alpha_in_valid), 0);
      check("rst_llr_load",       32'(bus.llr_load),       0);
      check("rst_dec_sel",        32'(bus.dec_sel),        0);
      check("rst_iter_count",     32'(bus.iter_count),     0);
      check("rst_busy",           32'(bus.busy),           0);
      check("rst_done",           32'(bus.done),           0);
      check("rst_timeout_err",    32'(bus.timeout_err),    0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // num_iter=1, L=11
      run_frame(1, 11, 0, 0, 0, 3);
      check("n1_launches",   32'(q_aiv.size()), 2);
      check("n1_aiv_first",  32'(qget(q_aiv, 0)), 1);
      check("n1_aiv_second", 32'(qget(q_aiv, 1)), 14);
      check("n1_llr_first",  32'(qget(q_llr, 0)), 13);
      check("n1_llr_second", 32'(qget(q_llr, 1)), 26);
      check("n1_dec_first",  32'(qget(q_dec_launch, 0)), 0);
      check("n1_dec_second", 32'(qget(q_dec_launch, 1)), 1);
      check("n1_done_cycle", 32'(done_at), 27);
      check("n1_iter_count", 32'(bus.iter_count), 1);

      // num_iter=3
      run_frame(3, 11, 0, 0, 0, 2);
      check("n3_launches",   32'(q_aiv.size()), 6);
      check("n3_done_cycle", 32'(done_at), 79);
      check("n3_iter_count", 32'(bus.iter_count), 3);

      // num_iter=0 behaves as 1
      run_frame(0, 11, 0, 0, 0, 2);
      check("n0_launches",   32'(q_aiv.size()), 2);
      check("n0_done_cycle", 32'(done_at), 27);
      check("n0_iter_count", 32'(bus.iter_count), 1);

      // num_iter=4, early_stop held into the 2nd decoder-2 UPDATE (cycle 52)
      run_frame(4, 11, 0, 2, 1, 2);
      check("es_done_cycle", 32'(done_at), 53);
      check("es_iter_count", 32'(bus.iter_count), 2);
      check("es_launches",   32'(q_aiv.size()), 4);

      for (int f = 0; f < 30; f++) begin
         int pct;
         case ($urandom_range(2))
            0:       pct = 0;
            1:       pct = 15;
            default: pct = 40;
         endcase
         run_frame(int'($urandom_range(6)), int'($urandom_range(1, 14)), pct, 0, 1,
                   int'($urandom_range(4)));
      end

      // Reset in the middle of WAIT of decoder 2, iteration 2 (cycle 45).
      bus.num_iter = 3; bus.early_stop = 0;
      for (int c = 0; c < 45; c++) begin
         bus.start = (c == 0);
         bus.alpha_out_valid = (c >= 1 && (c - 1) % 13 == 11);
         @(posedge clk); #1;
      end
      bus.start = 0; bus.alpha_out_valid = 0;
      check("pre_rst_busy",       32'(bus.busy),       1);
      check("pre_rst_dec_sel",    32'(bus.dec_sel),    1);
      check("pre_rst_iter_count", 32'(bus.iter_count), 1);
      rst_n = 1'b0;
      #1;
      check("abort_dec_sel",     32'(bus.dec_sel),        0);
      check("abort_iter_count",  32'(bus.iter_count),     0);
      check("abort_busy",        32'(bus.busy),           0);
      check("abort_alpha_in",    32'(bus.alpha_in_valid), 0);
      check("abort_llr_load",    32'(bus.llr_load),       0);
      check("abort_done",        32'(bus.done),           0);
      check("abort_timeout_err", 32'(bus.timeout_err),    0);
      do_reset();
      for (int c = 0; c < 40; c++) begin
         bus.alpha_out_valid = 1'($urandom_range(1));
         @(negedge clk);
         check("post_abort_done",  32'(bus.done),           0);
         check("post_abort_busy",  32'(bus.busy),           0);
         check("post_abort_alpha", 32'(bus.alpha_in_valid), 0);
         @(posedge clk); #1;
      end
      bus.alpha_out_valid = 0;

      // alpha chain never answers
      bus.num_iter = 1;
`ifdef TIMEOUT_EN
      for (int c = 0; c <= TO_CYC + 6; c++) begin
         bus.start = (c == 0);
         @(negedge clk);
         if (c >= 1) begin
            check("to_busy",        32'(bus.busy),           32'(c <= TO_CYC + 2));
            check("to_done",        32'(bus.done),           32'(c == TO_CYC + 2));
            check("to_timeout_err", 32'(bus.timeout_err),    32'(c >= TO_CYC + 2));
            check("to_llr_load",    32'(bus.llr_load),       0);
            check("to_alpha_in",    32'(bus.alpha_in_valid), 32'(c == 1));
         end
         @(posedge clk); #1;
      end
      m_prev_ic   = 0;
      m_prev_terr = 1;
`else
      for (int c = 0; c <= 200; c++) begin
         bus.start = (c == 0);
         @(negedge clk);
         if (c >= 1) begin
            check("hang_busy",        32'(bus.busy),           1);
            check("hang_done",        32'(bus.done),           0);
            check("hang_timeout_err", 32'(bus.timeout_err),    0);
            check("hang_alpha_in",    32'(bus.alpha_in_valid), 32'(c == 1));
         end
         @(posedge clk); #1;
      end
      do_reset();
`endif
      bus.start = 0;

      run_frame(2, 5, 0, 0, 1, 2);
      check("final_iter_count", 32'(bus.iter_count), 2);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
